// File: rtl/clint_pkg.sv
// Shared constants and types for the core-local interruptor.
// Offsets are byte offsets into the 64 KiB register window.
package clint_pkg;

    localparam logic [15:0] MSIP_OFF        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } clint_state_t;

    // Word-granular match: the two byte-select bits take no part in decode.
    function automatic logic word_match(input logic [13:0] word_addr, input logic [15:0] off);
        return word_addr == off[15:2];
    endfunction

endpackage

// File: rtl/mtime_counter.sv
// Prescaled 64-bit mtime counter with per-half software writes.
// A write on a tick edge wins over the increment; the prescaler keeps running.
module mtime_counter #(
    parameter int unsigned DIVIDER = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        write_lo,
    input  logic        write_hi,
    input  logic [31:0] wdata,
    output logic [63:0] mtime
);

    localparam logic [15:0] PreMax = 16'(DIVIDER - 1);

    logic [15:0] pre_q, pre_d;
    logic [63:0] mtime_q, mtime_d;
    logic        tick;

    always_comb begin
        tick    = (pre_q == PreMax);
        pre_d   = tick ? 16'd0 : pre_q + 16'd1;
        mtime_d = mtime_q;
        if (write_lo) begin
            mtime_d = {mtime_q[63:32], wdata};
        end else if (write_hi) begin
            mtime_d = {wdata, mtime_q[31:0]};
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q   <= 16'd0;
            mtime_q <= 64'd0;
        end else begin
            pre_q   <= pre_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime = mtime_q;

endmodule

// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a single-outstanding
// valid/ready register port, driving the core's timer and software interrupts.
module clint
    import clint_pkg::*;
#(
    parameter int unsigned DIVIDER = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        software_interrupt,
    output logic        timer_interrupt
);

    clint_state_t state_q, state_d;
    logic [31:0]  rdata_q, rdata_d;
    logic [63:0]  mtimecmp_q, mtimecmp_d;
    logic         msip_q, msip_d;
    logic         tint_q, tint_d;

    logic [63:0]  mtime;
    logic [13:0]  word_addr;
    logic         accept;
    logic         wr;
    logic [31:0]  rd_mux;
    logic         unused_addr;

    assign word_addr   = req_addr[15:2];
    assign unused_addr = ^req_addr[1:0];
    assign accept      = (state_q == IDLE) && req_valid;
    assign wr          = accept && req_write;

    mtime_counter #(
        .DIVIDER (DIVIDER)
    ) u_mtime_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .write_lo (wr && word_match(word_addr, MTIME_LO_OFF)),
        .write_hi (wr && word_match(word_addr, MTIME_HI_OFF)),
        .wdata    (req_wdata),
        .mtime    (mtime)
    );

    // Read data reflects register state before this edge's updates.
    always_comb begin
        rd_mux = 32'd0;
        if (word_match(word_addr, MSIP_OFF)) begin
            rd_mux = {31'd0, msip_q};
        end else if (word_match(word_addr, MTIMECMP_LO_OFF)) begin
            rd_mux = mtimecmp_q[31:0];
        end else if (word_match(word_addr, MTIMECMP_HI_OFF)) begin
            rd_mux = mtimecmp_q[63:32];
        end else if (word_match(word_addr, MTIME_LO_OFF)) begin
            rd_mux = mtime[31:0];
        end else if (word_match(word_addr, MTIME_HI_OFF)) begin
            rd_mux = mtime[63:32];
        end
    end

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        tint_d     = (mtime >= mtimecmp_q);

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = RESP;
                    rdata_d = req_write ? 32'd0 : rd_mux;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr) begin
            if (word_match(word_addr, MSIP_OFF)) begin
                msip_d = req_wdata[0];
            end
            if (word_match(word_addr, MTIMECMP_LO_OFF)) begin
                mtimecmp_d[31:0] = req_wdata;
            end
            if (word_match(word_addr, MTIMECMP_HI_OFF)) begin
                mtimecmp_d[63:32] = req_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rdata_q    <= 32'd0;
            msip_q     <= 1'b0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            tint_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
            tint_q     <= tint_d;
        end
    end

    assign req_ready          = (state_q == IDLE);
    assign resp_valid         = (state_q == RESP);
    assign resp_rdata         = rdata_q;
    assign software_interrupt = msip_q;
    assign timer_interrupt    = tint_q;

endmodule
